// File: rtl/led_pattern_gen_pkg.sv
// Shared types and widths for the multi-channel LED pattern generator.
package led_pkg;

    localparam int MODE_W = 2;
    localparam int DUTY_W = 8;

    typedef enum logic [MODE_W-1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_e;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_dir_e;

    localparam logic [DUTY_W-1:0] DUTY_TOP = '1;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Host-side configuration port of the LED pattern generator (valid/ready write channel).
interface led_pattern_gen_if #(
    parameter int PW = 10
);
    import led_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_ch;
    logic [MODE_W-1:0] cfg_mode;
    logic [PW-1:0]     cfg_half_per;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_half_per,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_half_per,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// Shared prescaler: emits a one-cycle strobe every DIV enabled clocks.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic CLK100MHZ,
    input  logic RST,
    input  logic EN,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_pcnt;
    logic          w_last;

    assign w_last = (r_pcnt == LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_pcnt <= '0;
        end else if (EN) begin
            r_pcnt <= w_last ? '0 : r_pcnt + CW'(1);
        end
    end

    // Gated so a counter frozen on its last value does not hold the strobe high.
    assign tick = EN && !RST && w_last;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BREATHE modes on a shared tick and PWM counter.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1_000,
    parameter int CHANNELS    = 4,
    parameter int PW          = 10
) (
    input  logic                CLK100MHZ,
    input  logic                RST,
    input  logic                EN,
    led_pattern_gen_if.slave    cfg,
    output logic                tick,
    output logic [CHANNELS-1:0] LED
);

    localparam int         TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam logic [4:0] CH_LIM   = 5'(CHANNELS);

    function automatic logic [PW-1:0] f_half_last(input logic [PW-1:0] half);
        return (half == '0) ? '0 : half - PW'(1);
    endfunction

    function automatic logic [DUTY_W-1:0] f_ramp_duty(input logic [DUTY_W-1:0] duty,
                                                      input ramp_dir_e         dir);
        if (dir == RAMP_UP) begin
            return (duty == DUTY_TOP) ? DUTY_TOP - DUTY_W'(1) : duty + DUTY_W'(1);
        end
        return (duty == '0) ? DUTY_W'(1) : duty - DUTY_W'(1);
    endfunction

    function automatic ramp_dir_e f_ramp_dir(input logic [DUTY_W-1:0] duty,
                                             input ramp_dir_e         dir);
        if ((dir == RAMP_UP) && (duty == DUTY_TOP)) begin
            return RAMP_DOWN;
        end
        if ((dir == RAMP_DOWN) && (duty == '0)) begin
            return RAMP_UP;
        end
        return dir;
    endfunction

    logic              r_ready;
    logic              r_err;
    logic [DUTY_W-1:0] r_pwm;
    logic              w_wr;
    logic              w_ch_ok;
    logic              w_wr_ok;
    logic              w_tick;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
        .EN        (EN),
        .tick      (w_tick)
    );

    assign tick = w_tick;

    assign w_wr    = cfg.cfg_valid && r_ready;
    assign w_ch_ok = ({1'b0, cfg.cfg_ch} < CH_LIM);
    assign w_wr_ok = w_wr && w_ch_ok;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_wr && !w_ch_ok;
        end
    end

    assign cfg.cfg_ready = r_ready;
    assign cfg.cfg_err   = r_err;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_pwm <= '0;
        end else if (EN) begin
            r_pwm <= r_pwm + DUTY_W'(1);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [3:0] IDX = 4'(gi);

        led_mode_e         r_mode,  w_mode_nxt;
        logic [PW-1:0]     r_half,  w_half_nxt;
        logic [PW-1:0]     r_cnt,   w_cnt_nxt;
        logic              r_state, w_state_nxt;
        logic [DUTY_W-1:0] r_duty,  w_duty_nxt;
        ramp_dir_e         r_dir,   w_dir_nxt;
        logic              r_led,   w_led_nxt;
        logic              w_sel;

        assign w_sel = w_wr_ok && (cfg.cfg_ch == IDX);

        // A write to this channel takes priority over a coincident tick.
        always_comb begin
            w_mode_nxt  = r_mode;
            w_half_nxt  = r_half;
            w_cnt_nxt   = r_cnt;
            w_state_nxt = r_state;
            w_duty_nxt  = r_duty;
            w_dir_nxt   = r_dir;
            if (w_sel) begin
                w_mode_nxt  = led_mode_e'(cfg.cfg_mode);
                w_half_nxt  = cfg.cfg_half_per;
                w_cnt_nxt   = '0;
                w_state_nxt = 1'b0;
                w_duty_nxt  = '0;
                w_dir_nxt   = RAMP_UP;
            end else if (w_tick) begin
                case (r_mode)
                    LED_BLINK: begin
                        if (r_cnt == f_half_last(r_half)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = !r_state;
                        end else begin
                            w_cnt_nxt = r_cnt + PW'(1);
                        end
                    end
                    LED_BREATHE: begin
                        w_duty_nxt = f_ramp_duty(r_duty, r_dir);
                        w_dir_nxt  = f_ramp_dir(r_duty, r_dir);
                    end
                    default: begin
                    end
                endcase
            end
        end

        always_comb begin
            w_led_nxt = 1'b0;
            if (EN) begin
                case (r_mode)
                    LED_ON:      w_led_nxt = 1'b1;
                    LED_BLINK:   w_led_nxt = r_state;
                    LED_BREATHE: w_led_nxt = (r_pwm < r_duty);
                    default:     w_led_nxt = 1'b0;
                endcase
            end
        end

        always_ff @(posedge CLK100MHZ) begin
            if (RST) begin
                r_mode  <= LED_OFF;
                r_half  <= '0;
                r_cnt   <= '0;
                r_state <= 1'b0;
                r_duty  <= '0;
                r_dir   <= RAMP_UP;
                r_led   <= 1'b0;
            end else begin
                r_mode  <= w_mode_nxt;
                r_half  <= w_half_nxt;
                r_cnt   <= w_cnt_nxt;
                r_state <= w_state_nxt;
                r_duty  <= w_duty_nxt;
                r_dir   <= w_dir_nxt;
                r_led   <= w_led_nxt;
            end
        end

        assign LED[gi] = r_led;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: 10-clock tick, 4 channels, 4-bit half-period.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int CH = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          tick;
    logic [CH-1:0] led;

    led_pattern_gen_if #(.PW(PW)) cfg_if ();

    led_pattern_gen #(
        .CLK_FREQ_HZ (100),
        .TICK_HZ     (10),
        .CHANNELS    (CH),
        .PW          (PW)
    ) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .EN        (en),
        .cfg       (cfg_if),
        .tick      (tick),
        .LED       (led)
    );

    always #5 clk = ~clk;

    int n;
    int errors;
    int checks;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input led_mode_e mode, input logic [PW-1:0] hp);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_ch       = ch;
        cfg_if.cfg_mode     = mode;
        cfg_if.cfg_half_per = hp;
        step();
        cfg_if.cfg_valid    = 1'b0;
    endtask

    initial begin
        int pwm;
        int k;
        int d;
        n      = 0;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        en     = 1'b1;
        cfg_if.cfg_valid    = 1'b0;
        cfg_if.cfg_ch       = '0;
        cfg_if.cfg_mode     = '0;
        cfg_if.cfg_half_per = '0;

        // Reset state
        step(); step(); step();
        chk("rst_led",   32'(led), 0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 0);
        chk("rst_err",   32'(cfg_if.cfg_err), 0);
        chk("rst_tick",  32'(tick), 0);

        // Release; n counts edges since release
        rst = 1'b0;
        n   = 0;
        run_to(1);  chk("ready_rise", 32'(cfg_if.cfg_ready), 1);
        run_to(8);  chk("tick_8",  32'(tick), 0);
        run_to(9);  chk("tick_9",  32'(tick), 1);
        run_to(10); chk("tick_10", 32'(tick), 0);

        // ch0 BLINK, half-period 3 ticks: write at edge 11, toggles at edges 40, 70, 100
        cfg_write(4'd0, LED_BLINK, 4'd3);
        run_to(19); chk("tick_19", 32'(tick), 1);
        run_to(40); chk("blink_pre",  32'(led), 32'h0);
        run_to(41); chk("blink_on",   32'(led), 32'h1);
        run_to(70); chk("blink_hold", 32'(led), 32'h1);
        run_to(71); chk("blink_off",  32'(led), 32'h0);

        // Invalid channel, then ch1 ON
        cfg_write(4'd5, LED_ON, 4'd0);
        chk("err_pulse", 32'(cfg_if.cfg_err), 1);
        chk("err_led",   32'(led), 32'h0);
        run_to(73); chk("err_clear", 32'(cfg_if.cfg_err), 0);
        cfg_write(4'd1, LED_ON, 4'd0);
        chk("on_noerr", 32'(cfg_if.cfg_err), 0);
        chk("on_pre",   32'(led), 32'h0);
        run_to(75); chk("on_led1", 32'(led), 32'h2);

        // Rewrite ch0 in the cycle where tick=1 and cnt==2: no toggle at edge 100
        run_to(99); chk("tick_99", 32'(tick), 1);
        cfg_write(4'd0, LED_BLINK, 4'd3);
        run_to(101); chk("write_wins", 32'(led), 32'h2);

        // EN low for 25 edges (106..130): prescaler frozen at 5, ch0 cnt frozen at 0
        run_to(105);
        en = 1'b0;
        run_to(106); chk("en_off_led", 32'(led), 32'h0);
        run_to(119); chk("en_off_tick", 32'(tick), 0);
        run_to(130); chk("en_off_hold", 32'(led), 32'h0);
        en = 1'b1;
        run_to(131); chk("en_resume_led", 32'(led), 32'h2);
        run_to(134); chk("en_resume_tick", 32'(tick), 1);
        run_to(155); chk("resume_pre",    32'(led), 32'h2);
        run_to(156); chk("resume_toggle", 32'(led), 32'h3);

        // ch2 BREATHE written at edge 157; ticks update at edges 165, 175, ...
        // pwm after edge m (m>=130) is (m-25)%256, so LED after edge t compares (t-26)%256
        // with the duty after tick k=(t-156)/10 along the 0..255..0 triangle.
        cfg_write(4'd2, LED_BREATHE, 4'd0);
        for (int t = 158; t <= 5275; t++) begin
            run_to(t);
            pwm = (t - 26) % 256;
            k   = (t - 156) / 10;
            d   = (k <= 255) ? k : ((k <= 510) ? 510 - k : k - 510);
            chk("breathe_led2", 32'(led[2]), (pwm < d) ? 32'd1 : 32'd0);
        end
        chk("breathe_led1", 32'(led[1]), 1);

        // Reset mid-operation with a write in flight
        rst = 1'b1;
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_ch       = 4'd3;
        cfg_if.cfg_mode     = LED_ON;
        cfg_if.cfg_half_per = 4'd0;
        step();
        chk("rst2_led",   32'(led), 0);
        chk("rst2_ready", 32'(cfg_if.cfg_ready), 0);
        chk("rst2_err",   32'(cfg_if.cfg_err), 0);
        chk("rst2_tick",  32'(tick), 0);
        cfg_if.cfg_valid = 1'b0;
        step();
        rst = 1'b0;
        n   = 0;
        run_to(1);  chk("rst2_ready_rise", 32'(cfg_if.cfg_ready), 1);
        run_to(9);  chk("rst2_tick9", 32'(tick), 1);
        run_to(12); chk("rst2_led_12", 32'(led), 0);
        run_to(45); chk("rst2_led_45", 32'(led), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
